// File: rtl/postfix_evaluator_if.sv
// Token handshake between the infix-to-postfix converter (master) and the
// postfix evaluator (slave).
interface postfix_evaluator_if #(
  parameter int unsigned N = 8
);
  logic         tok_valid;
  logic         tok_is_op;
  logic [N-1:0] tok_data;
  logic         tok_ready;

  modport master (output tok_valid, output tok_is_op, output tok_data, input tok_ready);
  modport slave  (input tok_valid, input tok_is_op, input tok_data, output tok_ready);
endinterface

// File: rtl/postfix_evaluator.sv
// Postfix expression evaluator: operand stack plus a 4-state control FSM,
// emitting one N-bit result (or an error pulse) per '$'-terminated expression.
module postfix_evaluator #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  postfix_evaluator_if.slave     tok,
  output logic [N-1:0]           result,
  output logic                   result_valid,
  output logic                   error,
  output logic [$clog2(DEPTH):0] depth
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = AW + 1;

  localparam logic [N-1:0] OP_ADD = N'(43);
  localparam logic [N-1:0] OP_SUB = N'(45);
  localparam logic [N-1:0] OP_MUL = N'(42);
  localparam logic [N-1:0] OP_END = N'(36);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EXEC   = 2'd1,
    FINISH = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sp_q, sp_d;
  logic [N-1:0]  op_q, op_d;
  logic [N-1:0]  stack [DEPTH];

  logic          accept;
  logic          is_arith;
  logic          push;
  logic          exec_wr;
  logic          fin_ok;
  logic          fin_err;
  logic [AW-1:0] idx_a;
  logic [AW-1:0] idx_b;
  logic [N-1:0]  opnd_a;
  logic [N-1:0]  opnd_b;
  logic [N-1:0]  alu_out;

  assign tok.tok_ready = RESET_N && ((state_q == RUN) || (state_q == DRAIN));
  assign accept        = tok.tok_valid && tok.tok_ready;
  assign is_arith      = (tok.tok_data == OP_ADD) || (tok.tok_data == OP_SUB) ||
                         (tok.tok_data == OP_MUL);
  assign depth         = sp_q;

  assign idx_a  = AW'(sp_q - SW'(2));
  assign idx_b  = AW'(sp_q - SW'(1));
  assign opnd_a = stack[idx_a];
  assign opnd_b = stack[idx_b];

  always_comb begin
    alu_out = '0;
    case (op_q)
      OP_ADD:  alu_out = opnd_a + opnd_b;
      OP_SUB:  alu_out = opnd_a - opnd_b;
      OP_MUL:  alu_out = opnd_a * opnd_b;
      default: alu_out = '0;
    endcase
  end

  // The error latch is folded into the transition into FINISH: the outcome is
  // known when '$' is accepted, so both pulses are registered there and land
  // in the FINISH cycle together with the updated result.
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    op_d    = op_q;
    push    = 1'b0;
    exec_wr = 1'b0;
    fin_ok  = 1'b0;
    fin_err = 1'b0;
    case (state_q)
      RUN: begin
        if (accept) begin
          if (!tok.tok_is_op) begin
            if (sp_q < SW'(DEPTH)) begin
              push = 1'b1;
              sp_d = sp_q + SW'(1);
            end else begin
              state_d = DRAIN;
            end
          end else if (is_arith) begin
            if (sp_q >= SW'(2)) begin
              op_d    = tok.tok_data;
              state_d = EXEC;
            end else begin
              state_d = DRAIN;
            end
          end else if (tok.tok_data == OP_END) begin
            state_d = FINISH;
            if (sp_q == SW'(1)) fin_ok  = 1'b1;
            else                fin_err = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      EXEC: begin
        exec_wr = 1'b1;
        sp_d    = sp_q - SW'(1);
        state_d = RUN;
      end
      FINISH: begin
        sp_d    = '0;
        state_d = RUN;
      end
      DRAIN: begin
        if (accept && tok.tok_is_op && (tok.tok_data == OP_END)) begin
          fin_err = 1'b1;
          state_d = FINISH;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= RUN;
      sp_q         <= '0;
      op_q         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      op_q         <= op_d;
      result_valid <= fin_ok;
      error        <= fin_err;
      if (fin_ok) result <= stack[0];
    end
  end

  // Stack storage carries no reset; its contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      stack[sp_q[AW-1:0]] <= tok.tok_data;
    end else if (exec_wr) begin
      stack[idx_a] <= alu_out;
    end
  end

endmodule

// File: tb/tb_postfix_evaluator.sv
// Scoreboard bench for postfix_evaluator: expected results are queued when '$'
// is driven and checked by a monitor when result_valid/error pulse.
module tb_postfix_evaluator;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 16;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic [N-1:0] result;
  logic         result_valid;
  logic         error;
  logic [4:0]   depth;

  postfix_evaluator_if #(.N(N)) bus ();

  postfix_evaluator #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .tok          (bus.slave),
    .result       (result),
    .result_valid (result_valid),
    .error        (error),
    .depth        (depth)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic         is_err;
    logic [N-1:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  always @(negedge CLK) begin
    if (RESET_N && (result_valid || error)) begin
      tests++;
      if (result_valid && error) begin
        fails++;
        $display("FAIL both_pulses: result_valid=%b error=%b, required not both high", result_valid, error);
      end else if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: result_valid=%b error=%b result=%0d, required no pulse", result_valid, error, result);
      end else begin
        mon_e = sb.pop_front();
        if (error !== mon_e.is_err || (!mon_e.is_err && result !== mon_e.val)) begin
          fails++;
          $display("FAIL scoreboard: error=%b result=%0d, required error=%b result=%0d",
                   error, result, mon_e.is_err, mon_e.val);
        end
      end
    end
  end

  task automatic idle();
    bus.tok_valid = 1'b0;
    bus.tok_is_op = 1'b0;
    bus.tok_data  = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send(input logic op, input logic [N-1:0] d);
    int n;
    n = 0;
    bus.tok_valid = 1'b1;
    bus.tok_is_op = op;
    bus.tok_data  = d;
    while (!bus.tok_ready && n < 50) begin @(posedge CLK); #1; n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout: tok_ready=%b, required 1 within 50 cycles", bus.tok_ready);
    end else begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic expect_res(input logic is_err, input logic [N-1:0] v);
    exp_t e;
    e.is_err = is_err;
    e.val    = v;
    sb.push_back(e);
  endtask

  task automatic send_end(input logic is_err, input logic [N-1:0] v);
    expect_res(is_err, v);
    send(1'b1, 8'd36);
    idle();
  endtask

  task automatic drain_sb();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(posedge CLK); #1; n++; end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    cycles(1);
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (result !== 8'd0 || result_valid !== 1'b0 || error !== 1'b0 ||
        bus.tok_ready !== 1'b0 || depth !== 5'd0) begin
      fails++;
      $display("FAIL reset_state: result=%0d rv=%b err=%b ready=%b depth=%0d, required 0 0 0 0 0",
               result, result_valid, error, bus.tok_ready, depth);
    end
    cycles(2);
    RESET_N = 1'b1;
    cycles(1);
  endtask

  task automatic test_basic();
    send(1'b0, 8'd3);
    send(1'b0, 8'd4);
    send(1'b1, 8'd43);
    tests++;
    if (bus.tok_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_after_plus: tok_ready=%b, required 0", bus.tok_ready);
    end
    send(1'b0, 8'd2);
    send(1'b1, 8'd42);
    tests++;
    if (bus.tok_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_after_mul: tok_ready=%b, required 0", bus.tok_ready);
    end
    send_end(1'b0, 8'd14);
    tests++;
    if (result_valid !== 1'b1 || result !== 8'd14) begin
      fails++;
      $display("FAIL result_timing: rv=%b result=%0d, required rv=1 result=14", result_valid, result);
    end
    cycles(1);
    tests++;
    if (depth !== 5'd0 || result_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_after: depth=%0d rv=%b, required depth=0 rv=0", depth, result_valid);
    end
    drain_sb();
  endtask

  task automatic test_wrap();
    send(1'b0, 8'd5);  send(1'b0, 8'd9);  send(1'b1, 8'd45); send_end(1'b0, 8'd252);
    send(1'b0, 8'd20); send(1'b0, 8'd13); send(1'b1, 8'd42); send_end(1'b0, 8'd4);
    drain_sb();
  endtask

  task automatic test_underflow();
    send(1'b1, 8'd43); send(1'b0, 8'd7); send(1'b0, 8'd8); send_end(1'b1, 8'd0);
    drain_sb();
    tests++;
    if (result !== 8'd4) begin
      fails++;
      $display("FAIL underflow_hold: result=%0d, required 4", result);
    end
    send(1'b0, 8'd1); send(1'b0, 8'd1); send(1'b1, 8'd43); send_end(1'b0, 8'd2);
    drain_sb();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) send(1'b0, 8'(i + 1));
    tests++;
    if (depth !== 5'd16) begin
      fails++;
      $display("FAIL overflow_full: depth=%0d, required 16", depth);
    end
    send(1'b0, 8'd99);
    tests++;
    if (depth !== 5'd16 || bus.tok_ready !== 1'b1) begin
      fails++;
      $display("FAIL overflow_drain: depth=%0d ready=%b, required 16 1", depth, bus.tok_ready);
    end
    send_end(1'b1, 8'd0);
    drain_sb();
    tests++;
    if (depth !== 5'd0) begin
      fails++;
      $display("FAIL overflow_depth_after: depth=%0d, required 0", depth);
    end
  endtask

  task automatic test_bad_term();
    send(1'b0, 8'd1); send(1'b0, 8'd2); send_end(1'b1, 8'd0);
    drain_sb();
    send(1'b1, 8'd40);
    send(1'b0, 8'd36);
    idle();
    cycles(1);
    tests++;
    if (error !== 1'b0 || bus.tok_ready !== 1'b1) begin
      fails++;
      $display("FAIL operand_36_in_drain: error=%b ready=%b, required 0 1", error, bus.tok_ready);
    end
    send_end(1'b1, 8'd0);
    drain_sb();
  endtask

  task automatic test_async_reset();
    send(1'b0, 8'd3); send(1'b0, 8'd4);
    idle();
    tests++;
    if (depth !== 5'd2) begin
      fails++;
      $display("FAIL pre_reset_depth: depth=%0d, required 2", depth);
    end
    #2 RESET_N = 1'b0;
    #1;
    tests++;
    if (depth !== 5'd0 || bus.tok_ready !== 1'b0 || result !== 8'd0) begin
      fails++;
      $display("FAIL async_reset: depth=%0d ready=%b result=%0d, required 0 0 0", depth, bus.tok_ready, result);
    end
    cycles(2);
    #2 RESET_N = 1'b1;
    @(posedge CLK); #1;
    send(1'b0, 8'd6); send(1'b0, 8'd7); send(1'b1, 8'd42); send_end(1'b0, 8'd42);
    drain_sb();
  endtask

  task automatic test_back_to_back();
    send(1'b0, 8'd1); send(1'b0, 8'd2);
    idle();
    cycles(3);
    tests++;
    if (depth !== 5'd2) begin
      fails++;
      $display("FAIL idle_hold_depth: depth=%0d, required 2", depth);
    end
    send(1'b1, 8'd43); send(1'b0, 8'd3); send(1'b1, 8'd42); send_end(1'b0, 8'd9);
    send(1'b0, 8'd200); send(1'b0, 8'd100); send(1'b1, 8'd43); send_end(1'b0, 8'd44);
    send(1'b0, 8'd7); send_end(1'b0, 8'd7);
    drain_sb();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_wrap();
    test_underflow();
    test_overflow();
    test_bad_term();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
